// File: rtl/tpu_top.sv
// INT8 weight-stationary systolic matmul C = A x B (N x N); B is held in the PE array, A is streamed in skewed.
// Optional macro TPU_RELU_EN clamps negative C elements to zero before they are stored in result.
module tpu_top #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N*DATA_W-1:0]     act_data,
    input  logic [N*DATA_W-1:0]     weight_data,
    output logic                    done,
    output logic                    output_valid,
    output logic [N*N*ACC_W-1:0]    result
);

    localparam int CNT_W  = $clog2(3 * N);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_A  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic                       valid_q, valid_d;
    logic signed [DATA_W-1:0]   w_q    [N][N];
    logic signed [DATA_W-1:0]   w_d    [N][N];
    logic signed [DATA_W-1:0]   abuf_q [N][N];
    logic signed [DATA_W-1:0]   abuf_d [N][N];
    logic signed [DATA_W-1:0]   a_q    [N][N];
    logic signed [DATA_W-1:0]   a_d    [N][N];
    logic signed [ACC_W-1:0]    p_q    [N][N];
    logic signed [ACC_W-1:0]    p_d    [N][N];
    logic signed [ACC_W-1:0]    res_q  [N][N];
    logic signed [ACC_W-1:0]    res_d  [N][N];
    logic signed [DATA_W-1:0]   a_in   [N][N];
    logic signed [ACC_W-1:0]    p_in   [N][N];

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] w
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(w);
        return acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

    function automatic logic signed [ACC_W-1:0] post(input logic signed [ACC_W-1:0] v);
`ifdef TPU_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Array wiring: row k gets A[i][k] at compute cycle i+k; activations move right, psums move down.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            a_in[k][0] = '0;
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CNT_W'(i + k)) begin
                    a_in[k][0] = abuf_q[i][k];
                end
            end
            for (int j = 1; j < N; j++) begin
                a_in[k][j] = a_q[k][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            p_in[0][j] = '0;
            for (int k = 1; k < N; k++) begin
                p_in[k][j] = p_q[k-1][j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        w_d     = w_q;
        abuf_d  = abuf_q;
        res_d   = res_q;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_d[r][c] = '0;
                p_d[r][c] = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (cnt_q == CNT_W'(r)) w_d[r][c] = weight_data[c*DATA_W +: DATA_W];
                    end
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_A: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (cnt_q == CNT_W'(r)) abuf_d[r][c] = act_data[c*DATA_W +: DATA_W];
                    end
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMPUTE: begin
                for (int k = 0; k < N; k++) begin
                    for (int j = 0; j < N; j++) begin
                        a_d[k][j] = a_in[k][j];
                        p_d[k][j] = mac(p_in[k][j], a_in[k][j], w_q[k][j]);
                    end
                end
                // Bottom of column j holds C[i][j] one cycle after it was formed at i+j+N-1.
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (cnt_q == CNT_W'(i + j + N)) res_d[i][j] = post(p_q[N-1][j]);
                    end
                end
                if (cnt_q == CNT_W'(3 * N - 2)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_q[r][c]    <= '0;
                    abuf_q[r][c] <= '0;
                    a_q[r][c]    <= '0;
                    p_q[r][c]    <= '0;
                    res_q[r][c]  <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            w_q     <= w_d;
            abuf_q  <= abuf_d;
            a_q     <= a_d;
            p_q     <= p_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                result[(i*N+j)*ACC_W +: ACC_W] = res_q[i][j];
            end
        end
    end

    assign done         = done_q;
    assign output_valid = valid_q;

endmodule

// File: tb/tb_tpu_top.sv
// Directed + random jobs for tpu_top checked against a plain matrix-product model.
module tb_tpu_top;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [N*DW-1:0]    act_data;
    logic [N*DW-1:0]    weight_data;
    logic               done;
    logic               output_valid;
    logic [N*N*AW-1:0]  result;

    tpu_top #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .act_data(act_data), .weight_data(weight_data),
        .done(done), .output_valid(output_valid), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int a_m    [N][N];
    int b_m    [N][N];
    int exp_c  [N][N];
    int prev_c [N][N];
    int e0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic signed [AW-1:0] res_el(input int i, input int j);
        return result[(i*N+j)*AW +: AW];
    endfunction

    function automatic logic [N*DW-1:0] a_row(input int r);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(a_m[r][j]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] b_row(input int r);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(b_m[r][j]);
        return v;
    endfunction

    task automatic build_model();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += a_m[i][k] * b_m[k][j];
`ifdef TPU_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_c[i][j] = s;
            end
        end
    endtask

    task automatic load_job(input bit mid_start, input bit check_prev);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        e0    = cyc;
        start = 1'b0;
        if (check_prev) begin
            chk("restart_valid_drop", output_valid, 0);
            chk("restart_kept_00", res_el(0, 0), prev_c[0][0]);
            chk("restart_kept_NN", res_el(N-1, N-1), prev_c[N-1][N-1]);
        end
        for (int r = 0; r < N; r++) begin
            weight_data = b_row(r);
            act_data    = $urandom;
            @(negedge clk);
        end
        for (int r = 0; r < N; r++) begin
            act_data    = a_row(r);
            weight_data = $urandom;
            start       = mid_start && (r == 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        int early_done;
        early_done = 0;
        while (!output_valid && (cyc - e0) < 5*N + 10) begin
            if (done) early_done++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, cyc - e0, 5*N - 1);
        chk({tag, "_valid"}, output_valid, 1);
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_early_done"}, early_done, 0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk($sformatf("%s_c%0d%0d", tag, i, j), res_el(i, j), exp_c[i][j]);
            end
        end
        @(negedge clk);
        chk({tag, "_done_single"}, done, 0);
        chk({tag, "_valid_hold"}, output_valid, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_frozen"}, res_el(N-1, 0), exp_c[N-1][0]);
        chk({tag, "_no_redone"}, done, 0);
        prev_c = exp_c;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; act_data = '0; weight_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_done", done, 0);
        chk("reset_valid", output_valid, 0);
        chk("reset_result", result === '0, 1);
        rst = 1'b0;

        // identity A, B[i][j] = i+j+1
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = (i == j) ? 1 : 0;
                b_m[i][j] = i + j + 1;
            end
        build_model();
        load_job(1'b0, 1'b0);
        finish_job("ident");

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin a_m[i][j] = -128; b_m[i][j] = -128; end
        build_model();
        load_job(1'b0, 1'b1);
        finish_job("neg_neg");

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin a_m[i][j] = -128; b_m[i][j] = 127; end
        build_model();
        load_job(1'b0, 1'b1);
        finish_job("neg_pos");

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin a_m[i][j] = i - j; b_m[i][j] = 1; end
        build_model();
        load_job(1'b0, 1'b1);
        finish_job("diff_ones");

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_m[i][j] = int'($urandom_range(0, 255)) - 128;
                    b_m[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            build_model();
            load_job(t == 1, 1'b1);
            finish_job($sformatf("rand%0d", t));
        end

        // reset in the middle of COMPUTE discards the job
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = int'($urandom_range(0, 255)) - 128;
                b_m[i][j] = int'($urandom_range(0, 255)) - 128;
            end
        load_job(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", output_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result === '0, 1);
        repeat (12) @(negedge clk);
        chk("midrst_stays_idle", output_valid, 0);
        chk("midrst_result_stays", result === '0, 1);
        build_model();
        load_job(1'b0, 1'b0);
        finish_job("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tpu_top.md
# tpu_top

INT8 weight-stationary systolic matrix-multiply engine computing C = A × B for square N×N signed 8-bit matrices, with 32-bit signed accumulation. It is the top of the accelerator datapath. A single `start` pulse begins a job: B is streamed in row by row and held stationary in an N×N PE array, then A is streamed in row by row. The full C matrix is presented on a flat result bus with a valid flag.

## Interface
- `N`, default 4: array dimension (rows and columns of A, B, C); must be ≥ 2.
- `DATA_W`, default 8: operand width, signed two's complement.
- `ACC_W`, default 32: accumulator and result element width, signed.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  job start; sampled only in IDLE or DONE.
- `act_data`  in  N*DATA_W  one row of A; element j is at `[j*DATA_W +: DATA_W]`.
- `weight_data`  in  N*DATA_W  one row of B; element j is at `[j*DATA_W +: DATA_W]`.
- `done`  out  1  single-cycle pulse when the result becomes valid.
- `output_valid`  out  1  level; `result` holds a complete C.
- `result`  out  N*N*ACC_W  C[i][j] is at `[(i*N+j)*ACC_W +: ACC_W]`.

## Operation
- FSM states: IDLE → LOAD_W → LOAD_A → COMPUTE → DONE.
- **IDLE:** waits for `start`=1, then moves to LOAD_W with the row counter cleared.
- **LOAD_W:** takes N consecutive cycles, row r = 0..N-1. `weight_data` is captured into stationary register W[r][j] of PE(r,j). After row N-1 the FSM moves to LOAD_A.
- **LOAD_A:** takes N consecutive cycles, row r = 0..N-1. `act_data` is captured into activation buffer A[r][*]. After row N-1 the FSM moves to COMPUTE.
- **COMPUTE:** A rows are injected into the array with skew.
  - A[i][k] enters array row k at cycle i+k.
  - Partial sums flow down each column: psum_out = psum_in + A·W.
  - Column j's bottom output at cycle i+j+N-1 is C[i][j] = Σk A[i][k]·B[k][j].
  - That output is written into `result` slot (i,j).
  - COMPUTE lasts exactly 3N-1 cycles (drain included), then the FSM moves to DONE.
- **DONE:**
  - `output_valid`=1 and `result` is frozen.
  - `done` is high only on the first DONE cycle.
  - `start`=1 in DONE begins a new job: the FSM moves to LOAD_W, `output_valid` clears, and `result` is kept until overwritten.
- Arithmetic:
  - Each product is signed 8×8 → 16 bits, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W; no saturation.
- `start` outside IDLE/DONE is ignored.
- `act_data` and `weight_data` are ignored outside their load states.

## Timing
- Reset values: `done`=0, `output_valid`=0, `result`=0, all W/A/psum registers 0, FSM in IDLE.
- Job timing, with start sampled at rising edge E0:
  - Weight rows are sampled at E1..EN.
  - Activation rows are sampled at E(N+1)..E(2N).
  - `output_valid` and `done` rise after edge E(5N-1): edge E19 for N=4.
- Input ordering requirement: the source drives row r before the edge at which it is sampled and holds it for one cycle. No per-row valid signal exists; rows must be back-to-back.
- `rst` asserted in any state, including mid-COMPUTE:
  - On the next edge the FSM returns to IDLE and all outputs clear.
  - A partial job is discarded.

## Configuration
- `TPU_RELU_EN`
  - Defined: each C element is passed through ReLU before it is written to `result`; negative values become 0.
  - Undefined (default): the raw signed sum is written.

## Test plan
- A = identity, B[i][j] = i+j+1, N=4 → `result` equals B (for example C[0][0]=1, C[3][3]=7), `output_valid` rises 19 cycles after the start edge, and `done` pulses once.
- All A = -128, all B = -128 → every C = 65536. All A = -128, all B = 127 → every C = -65024; this case checks ReLU behaviour per the macro.
- A[i][j] = i-j, B = all ones → C[i][j] = Σk(i-k), for example row 0 = -6 and row 3 = 6.
- Pulse `start` during LOAD_A → ignored; the result is unaffected and the latency is unchanged.
- Assert `rst` mid-COMPUTE → next cycle `output_valid`=0 and `result`=0, the FSM is in IDLE, and a fresh job then completes correctly.
- Two back-to-back jobs, with `start` in DONE → `output_valid` drops, then rises again with the second C; `done` pulses once per job.
